tdc_pair_diff: RTL and testbench

Parametrised successor of the TDC sample-pair differencer in the de0_iii_tdc path. Groups consecutive TDC samples into (A, B) pairs and computes B−A (noise check) or A+B−OFFSET (sum mode) at full signed width. Optionally averages 2^LOG2_AVG pair results. Presents the result on a valid/ready output instead of a one-cycle strobe. Sits between the TDC multi-sample front end and the result FIFO/UART packer.

---
 rtl/tdc_pair_pkg.sv | 19 +
 rtl/tdc_pair_acc.sv | 76 +++++++
 rtl/tdc_pair_diff.sv | 158 +++++++++++++++
 tb/tb_tdc_pair_diff.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pair_pkg.sv
// Shared types and counter widths for the TDC sample-pair differencer.
package tdc_pair_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAVE_A = 2'd1,
    CALC   = 2'd2,
    OUT    = 2'd3
  } state_e;

  typedef enum logic {
    MODE_DIFF = 1'b0,
    MODE_SUM  = 1'b1
  } mode_e;

  localparam int DROP_CNT_W = 16;
  localparam int PAIR_CNT_W = 8;

endpackage

// File: rtl/tdc_pair_acc.sv
// Averaging window for tdc_pair_diff: sums 2^LOG2_AVG signed pair results
// and reports the floor average when the window closes.
module tdc_pair_acc
  import tdc_pair_pkg::*;
#(
  parameter int W        = 37,
  parameter int LOG2_AVG = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic [W:0] r,
  output logic       done,
  output logic [W:0] avg
);

  localparam int AW    = W + 1 + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] WIN_LEN = CNT_W'(2 ** LOG2_AVG);

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] base_s, r_ext_s, sum_s;
  logic signed [W:0]    r_s;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_base_s, cnt_next_s;
  logic                 mode_q, mode_d, restart_s;

  // Window arithmetic; a mode change restarts the window with this pair.
  always_comb begin
    r_s       = $signed(r);
    r_ext_s   = r_s;
    restart_s = (cnt_q != {CNT_W{1'b0}}) && (mode != mode_q);
    if (restart_s) begin
      base_s     = {AW{1'b0}};
      cnt_base_s = {CNT_W{1'b0}};
    end else begin
      base_s     = acc_q;
      cnt_base_s = cnt_q;
    end
    sum_s      = base_s + r_ext_s;
    cnt_next_s = cnt_base_s + CNT_W'(1);
    done       = (cnt_next_s == WIN_LEN);
    // Arithmetic shift then truncation to W+1 bits is exactly this slice.
    avg        = sum_s[AW-1:LOG2_AVG];

    acc_d  = acc_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (en) begin
      mode_d = mode;
      if (done) begin
        acc_d = {AW{1'b0}};
        cnt_d = {CNT_W{1'b0}};
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_next_s;
      end
    end else begin
      mode_d = mode_q;
    end
  end

  // Window state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= {AW{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      mode_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/tdc_pair_diff.sv
// Groups TDC samples into (A, B) pairs and emits B-A or A+B-OFFSET on a
// valid/ready port. Define TDC_PAIR_AVG_EN to average 2^LOG2_AVG pairs.
module tdc_pair_diff
  import tdc_pair_pkg::*;
#(
  parameter int         W        = 37,
  parameter logic [W:0] OFFSET   = '0,
  parameter int         LOG2_AVG = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_data,
  output logic                  in_ready,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W:0]            out_data,
  output logic                  out_mode,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic [PAIR_CNT_W-1:0] pair_cnt
);

  if ((LOG2_AVG < 0) || (LOG2_AVG > 8)) begin : g_log2_avg_range
    $error("tdc_pair_diff: LOG2_AVG must be within 0..8");
  end

  state_e                state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d;
  mode_e                 mode_q, mode_d;
  mode_e                 out_mode_q, out_mode_d;
  logic [W:0]            out_data_q, out_data_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic [PAIR_CNT_W-1:0] pair_q, pair_d;
  logic [W:0]            r_s, emit_data_s;
  logic                  in_ready_s, calc_s, emit_s;

  assign in_ready_s = (state_q == IDLE) || (state_q == HAVE_A);
  assign calc_s     = (state_q == CALC);

`ifdef TDC_PAIR_AVG_EN
  tdc_pair_acc #(
    .W        (W),
    .LOG2_AVG (LOG2_AVG)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .en   (calc_s),
    .mode (mode_q),
    .r    (r_s),
    .done (emit_s),
    .avg  (emit_data_s)
  );
`else
  assign emit_s      = 1'b1;
  assign emit_data_s = r_s;
`endif

  // Pair arithmetic at W+1 bits, wrapping, plus FSM next state and counters.
  always_comb begin
    if (mode_q == MODE_SUM) begin
      r_s = {1'b0, a_q} + {1'b0, b_q} - OFFSET;
    end else begin
      r_s = {1'b0, b_q} - {1'b0, a_q};
    end

    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    out_mode_d = out_mode_q;
    pair_d     = pair_q;
    drop_d     = drop_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_data;
          mode_d  = mode_e'(mode);
          state_d = HAVE_A;
        end else begin
          state_d = IDLE;
        end
      end
      HAVE_A: begin
        if (in_valid) begin
          b_d     = in_data;
          state_d = CALC;
        end else begin
          state_d = HAVE_A;
        end
      end
      CALC: begin
        if (emit_s) begin
          out_data_d = emit_data_s;
          out_mode_d = mode_q;
          state_d    = OUT;
        end else begin
          state_d = IDLE;
        end
      end
      OUT: begin
        if (out_ready) begin
          pair_d  = pair_q + PAIR_CNT_W'(1);
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The source cannot stall, so anything offered while busy is lost.
    if (in_valid && !in_ready_s) begin
      if (drop_q != {DROP_CNT_W{1'b1}}) begin
        drop_d = drop_q + DROP_CNT_W'(1);
      end else begin
        drop_d = drop_q;
      end
    end else begin
      drop_d = drop_q;
    end
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      a_q        <= {W{1'b0}};
      b_q        <= {W{1'b0}};
      mode_q     <= MODE_DIFF;
      out_data_q <= {(W+1){1'b0}};
      out_mode_q <= MODE_DIFF;
      drop_q     <= {DROP_CNT_W{1'b0}};
      pair_q     <= {PAIR_CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
      out_mode_q <= out_mode_d;
      drop_q     <= drop_d;
      pair_q     <= pair_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;
  assign drop_cnt  = drop_q;
  assign pair_cnt  = pair_q;

endmodule

// File: tb/tb_tdc_pair_diff.sv
// Self-checking bench for tdc_pair_diff: directed cases plus randomized pairs
// checked against an arithmetic reference model.
module tb_tdc_pair_diff;

  localparam int         W      = 37;
  localparam logic [W:0] OFFSET = 38'd1000;
`ifdef TDC_PAIR_AVG_EN
  localparam int L = 2;
`else
  localparam int L = 3;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   out_data;
  logic         out_mode;
  logic [15:0]  drop_cnt;
  logic [7:0]   pair_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  longint win_sum;
  int     win_n;
  logic   win_mode;

  tdc_pair_diff #(.W(W), .OFFSET(OFFSET), .LOG2_AVG(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .drop_cnt(drop_cnt), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_r(input longint a, input longint b, input logic m);
    longint v;
    v = m ? (a + b - longint'(OFFSET)) : (b - a);
    return v[W:0];
  endfunction

  function automatic longint to_signed(input logic [W:0] v);
    return v[W] ? (longint'(v) - (longint'(1) << (W + 1))) : longint'(v);
  endfunction

  task automatic model_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                            output logic has_out, output logic [W:0] val);
`ifdef TDC_PAIR_AVG_EN
    longint n, q;
    n = longint'(1) << L;
    if (win_n > 0 && m != win_mode) begin
      win_sum = 0;
      win_n   = 0;
    end
    win_sum  = win_sum + to_signed(ref_r(a, b, m));
    win_n    = win_n + 1;
    win_mode = m;
    has_out  = 1'b0;
    val      = '0;
    if (win_n == n) begin
      q = win_sum / n;
      if ((win_sum % n) != 0 && win_sum < 0) q = q - 1;
      val     = q[W:0];
      has_out = 1'b1;
      win_sum = 0;
      win_n   = 0;
    end
`else
    has_out = 1'b1;
    val     = ref_r(a, b, m);
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    win_sum = 0; win_n = 0; win_mode = 1'b0;
    @(negedge clk);
  endtask

  // Drives one pair with out_ready high and records what the output port showed.
  task automatic do_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         output logic v_calc, output logic v_out, output logic [W:0] d_out,
                         output logic m_out, output logic v_after);
    in_valid = 1'b1; in_data = a; mode = m; out_ready = 1'b1;
    @(negedge clk);
    in_data = b; mode = ~m;
    @(negedge clk);
    in_valid = 1'b0;
    v_calc = out_valid;
    @(negedge clk);
    v_out = out_valid; d_out = out_data; m_out = out_mode;
    @(negedge clk);
    v_after = out_valid;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({out_valid, out_data, out_mode, drop_cnt, pair_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b d=%0d m=%0b drop=%0d pair=%0d, expected all 0",
               out_valid, out_data, out_mode, drop_cnt, pair_cnt);
    end
    apply_reset();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
    end
  endtask

`ifndef TDC_PAIR_AVG_EN
  task automatic test_diff();
    logic vc, vo, mo, va;
    logic [W:0] d;
    apply_reset();
    do_pair(37'd100, 37'd350, 1'b0, vc, vo, d, mo, va);
    n_tests++;
    if ({vc, vo, mo, va} !== 4'b0100) begin
      n_fail++;
      $display("FAIL diff_valid_pulse: got calc/out/mode/after=%b expected 0100", {vc, vo, mo, va});
    end
    n_tests++;
    if (d !== 38'd250) begin
      n_fail++;
      $display("FAIL diff_data: got %0d expected 250", d);
    end
    n_tests++;
    if (pair_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL diff_pair_cnt: got %0d expected 1", pair_cnt);
    end
  endtask

  task automatic test_negative_and_max();
    logic vc, vo, mo, va;
    logic [W:0] d, e;
    do_pair(37'd500, 37'd200, 1'b0, vc, vo, d, mo, va);
    e = 38'd0 - 38'd300;
    n_tests++;
    if (vo !== 1'b1 || d !== e) begin
      n_fail++;
      $display("FAIL neg_diff: got v=%0b d=%h expected v=1 d=%h", vo, d, e);
    end
    do_pair(37'd0, {W{1'b1}}, 1'b0, vc, vo, d, mo, va);
    e = {1'b0, {W{1'b1}}};
    n_tests++;
    if (vo !== 1'b1 || d !== e) begin
      n_fail++;
      $display("FAIL max_width: got v=%0b d=%h expected v=1 d=%h", vo, d, e);
    end
  endtask

  task automatic test_sum();
    logic vc, vo, mo, va;
    logic [W:0] d;
    do_pair(37'd600, 37'd700, 1'b1, vc, vo, d, mo, va);
    n_tests++;
    if (vo !== 1'b1 || d !== 38'd300 || mo !== 1'b1) begin
      n_fail++;
      $display("FAIL sum_mode: got v=%0b d=%0d m=%0b expected v=1 d=300 m=1", vo, d, mo);
    end
  endtask

  task automatic test_backpressure();
    logic vc, vo, mo, va;
    logic [W:0] d;
    apply_reset();
    in_valid = 1'b1; in_data = 37'd10; mode = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_data = 37'd30;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 2 || i == 5 || i == 8);
      in_data  = 37'd5000 + 37'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 38'd20 || drop_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL bp_hold: got v=%0b d=%0d drop=%0d expected v=1 d=20 drop=3",
               out_valid, out_data, drop_cnt);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 37'd999;
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (drop_cnt !== 16'd4 || out_valid !== 1'b0 || pair_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL bp_handshake: got drop=%0d v=%0b pair=%0d expected drop=4 v=0 pair=1",
               drop_cnt, out_valid, pair_cnt);
    end
    do_pair(37'd40, 37'd45, 1'b0, vc, vo, d, mo, va);
    n_tests++;
    if (vo !== 1'b1 || d !== 38'd5) begin
      n_fail++;
      $display("FAIL bp_next_is_a: got v=%0b d=%0d expected v=1 d=5", vo, d);
    end
  endtask

  task automatic test_reset_mid_pair();
    logic vc, vo, mo, va;
    logic [W:0] d;
    in_valid = 1'b1; in_data = 37'd777; mode = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({out_valid, out_data, out_mode, drop_cnt, pair_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_pair: got v=%0b d=%0d m=%0b drop=%0d pair=%0d, expected all 0",
               out_valid, out_data, out_mode, drop_cnt, pair_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    do_pair(37'd100, 37'd350, 1'b0, vc, vo, d, mo, va);
    n_tests++;
    if (vo !== 1'b1 || d !== 38'd250 || mo !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_pair: got v=%0b d=%0d m=%0b expected v=1 d=250 m=0", vo, d, mo);
    end
  endtask
`else
  task automatic test_avg();
    logic vc, vo, mo, va;
    logic [W:0] d, e;
    logic [W-1:0] as [8] = '{37'd0, 37'd0, 37'd6, 37'd0, 37'd1, 37'd1, 37'd1, 37'd2};
    logic [W-1:0] bs [8] = '{37'd10, 37'd20, 37'd0, 37'd4, 37'd0, 37'd0, 37'd0, 37'd0};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      do_pair(as[i], bs[i], 1'b0, vc, vo, d, mo, va);
      e = (i == 3) ? 38'd7 : (38'd0 - 38'd2);
      n_tests++;
      if (vo !== ((i % 4) == 3) || (vo === 1'b1 && d !== e)) begin
        n_fail++;
        $display("FAIL avg_pair%0d: got v=%0b d=%h expected v=%0b d=%h", i, vo, d, (i % 4) == 3, e);
      end
    end
  endtask

  task automatic test_reset_mid_avg();
    logic vc, vo, mo, va;
    logic [W:0] d;
    do_pair(37'd0, 37'd100, 1'b0, vc, vo, d, mo, va);
    do_pair(37'd0, 37'd100, 1'b0, vc, vo, d, mo, va);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({out_valid, out_data, out_mode, drop_cnt, pair_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_avg: got v=%0b d=%0d pair=%0d, expected all 0", out_valid, out_data, pair_cnt);
    end
    rst = 1'b1;
    win_sum = 0; win_n = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      do_pair(37'd0, 37'(i == 3 ? 6 : i + 1), 1'b0, vc, vo, d, mo, va);
    end
    n_tests++;
    if (vo !== 1'b1 || d !== 38'd3) begin
      n_fail++;
      $display("FAIL fresh_window: got v=%0b d=%0d expected v=1 d=3", vo, d);
    end
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         m, has_out, iv;
    logic [W:0]   exp_d;
    int           exp_drop, exp_pair, waits;
    apply_reset();
    exp_drop = 0; exp_pair = 0;
    for (int p = 0; p < 80; p++) begin
      a = W'({$urandom, $urandom});
      b = W'({$urandom, $urandom});
      if ($urandom_range(0, 5) == 0) a = '0;
      if ($urandom_range(0, 5) == 0) b = {W{1'b1}};
      m = $urandom_range(0, 3) == 0;
      model_pair(a, b, m, has_out, exp_d);
      in_valid = 1'b1; in_data = a; mode = m; out_ready = 1'b0;
      @(negedge clk);
      in_data = b; mode = $urandom_range(0, 1);
      @(negedge clk);
      iv = $urandom_range(0, 1);
      in_valid = iv; in_data = W'($urandom);
      if (iv) exp_drop++;
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++;
      if (out_valid !== has_out || (has_out && (out_data !== exp_d || out_mode !== m))) begin
        n_fail++;
        $display("FAIL rand_result%0d: got v=%0b d=%h m=%0b expected v=%0b d=%h m=%0b",
                 p, out_valid, out_data, out_mode, has_out, exp_d, m);
      end
      if (has_out) begin
        waits = $urandom_range(0, 3);
        for (int k = 0; k <= waits; k++) begin
          iv = $urandom_range(0, 1);
          in_valid = iv; in_data = W'($urandom);
          if (iv) exp_drop++;
          out_ready = (k == waits);
          @(negedge clk);
          in_valid = 1'b0;
          if (k < waits) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== exp_d) begin
              n_fail++;
              $display("FAIL rand_hold%0d: got v=%0b d=%h expected v=1 d=%h", p, out_valid, out_data, exp_d);
            end
          end
        end
        exp_pair++;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || pair_cnt !== 8'(exp_pair)) begin
          n_fail++;
          $display("FAIL rand_handshake%0d: got v=%0b pair=%0d expected v=0 pair=%0d",
                   p, out_valid, pair_cnt, 8'(exp_pair));
        end
      end
    end
    n_tests++;
    if (drop_cnt !== 16'(exp_drop) || pair_cnt !== 8'(exp_pair)) begin
      n_fail++;
      $display("FAIL rand_counters: got drop=%0d pair=%0d expected drop=%0d pair=%0d",
               drop_cnt, pair_cnt, exp_drop, 8'(exp_pair));
    end
  endtask

  initial begin
    win_sum = 0; win_n = 0; win_mode = 1'b0;
    test_reset();
`ifndef TDC_PAIR_AVG_EN
    test_diff();
    test_negative_and_max();
    test_sum();
    test_backpressure();
    test_reset_mid_pair();
`else
    test_avg();
    test_reset_mid_avg();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
